// File: rtl/start_signal_write_start_if.sv
// start_signal_write_start_if: Avalon-MM slave bus plus driven start lines for start_signal_write_start
interface start_signal_write_start_if #(
    parameter int DATA_WIDTH = 1
);
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic [DATA_WIDTH-1:0] out_port;
    logic                  pulse_done;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, out_port, pulse_done
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, out_port, pulse_done
    );
endinterface

// File: rtl/start_signal_write_start.sv
// start_signal_write_start: Avalon-MM write-side start/control port with optional hardware-timed pulse (START_SIGNAL_PULSE_EN)
module start_signal_write_start #(
    parameter int          DATA_WIDTH  = 1,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          CNT_WIDTH   = 16
) (
    input logic clk,
    input logic reset_n,
    start_signal_write_start_if.slave bus
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [31:0]           rd_nx;

    assign wr = bus.chipselect & ~bus.write_n;

    // DATA register: software-written level
    always_ff @(posedge clk) begin
        if (!reset_n)
            data_reg <= RESET_VALUE[DATA_WIDTH-1:0];
        else if (wr && bus.address == 2'd0)
            data_reg <= bus.writedata[DATA_WIDTH-1:0];
    end

`ifdef START_SIGNAL_PULSE_EN
    typedef enum logic {IDLE, PULSE} state_t;

    state_t                state, state_nx;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nx, len_reg;
    logic [DATA_WIDTH-1:0] mask_reg;
    logic                  busy, arm, done_set, done_sticky, pulse_done_r, go_wr;

    assign go_wr = wr && bus.address == 2'd2;
    assign busy  = state == PULSE;
    assign arm   = state == IDLE && go_wr && len_reg != '0;

    // FSM state and pulse counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pulse_done_r <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pulse_done_r <= done_set;
        end
    end

    // Next state: arm on GO with nonzero length, count down, finish when the last cycle elapses
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_set = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nx = PULSE;
                    cnt_nx   = len_reg;
                end
            end
            PULSE: begin
                if (cnt <= CNT_WIDTH'(1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_set = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_WIDTH'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pulse configuration and sticky completion flag; completion beats a same-edge clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_reg     <= CNT_WIDTH'(1);
            mask_reg    <= '0;
            done_sticky <= 1'b0;
        end else begin
            if (wr && bus.address == 2'd1)
                len_reg <= bus.writedata[CNT_WIDTH-1:0];
            if (arm)
                mask_reg <= bus.writedata[DATA_WIDTH-1:0];
            done_sticky <= done_set | (done_sticky & ~(wr && bus.address == 2'd3 && bus.writedata[1]));
        end
    end

    // Read mux: DATA, PULSE_LEN, GO (reads 0), STATUS
    always_comb begin
        rd_nx = bus.address == 2'd0 ? 32'(data_reg) :
                bus.address == 2'd1 ? 32'(len_reg) :
                bus.address == 2'd3 ? {16'(cnt), 14'd0, done_sticky, busy} : 32'd0;
    end

    assign bus.out_port   = data_reg | (busy ? mask_reg : '0);
    assign bus.pulse_done = pulse_done_r;
`else
    // Read mux: only DATA exists
    always_comb begin
        rd_nx = bus.address == 2'd0 ? 32'(data_reg) : 32'd0;
    end

    assign bus.out_port   = data_reg;
    assign bus.pulse_done = 1'b0;
`endif

    // Registered read data, one-cycle latency regardless of chipselect
    always_ff @(posedge clk) begin
        if (!reset_n)
            bus.readdata <= 32'd0;
        else
            bus.readdata <= rd_nx;
    end
endmodule

// File: tb/tb_start_signal_write_start.sv
// tb_start_signal_write_start: table vectors, corner sequences and random traffic against a timeline model
module tb_start_signal_write_start;
    localparam int          DW = 4;
    localparam logic [31:0] RV = 32'd1;
    localparam int          CW = 8;
`ifdef START_SIGNAL_PULSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    start_signal_write_start_if #(.DATA_WIDTH(DW)) bus();

    start_signal_write_start #(
        .DATA_WIDTH(DW),
        .RESET_VALUE(RV),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a pulse is a time window [arm edge, m_end) on an edge counter
    int              k = 0;
    int              m_end = -1;
    int              m_len = 1;
    logic [DW-1:0]   m_data = '0;
    logic [DW-1:0]   m_mask = '0;
    logic            m_sticky = 1'b0;
    logic            m_pd = 1'b0;
    logic [31:0]     m_rd = '0;
    logic [31:0]     last_out, last_rd;
    logic            last_pd;

    function automatic logic [31:0] p(input logic [31:0] x);
        return PEN ? x : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic model_edge(input logic rn, input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        logic busy_p;
        int   rem;
        k++;
        busy_p = (k - 1) < m_end;
        rem = busy_p ? m_end - (k - 1) : 0;
        if (!rn) begin
            m_data = RV[DW-1:0]; m_len = 1; m_mask = '0; m_end = -1;
            m_sticky = 1'b0; m_rd = '0; m_pd = 1'b0;
        end else begin
            m_rd = a == 2'd0 ? 32'(m_data) :
                   a == 2'd1 ? p(32'(m_len)) :
                   a == 2'd3 ? p((32'(rem) << 16) | {30'd0, m_sticky, busy_p}) : 32'd0;
            if (cs && !wn) begin
                if (a == 2'd0) m_data = wd[DW-1:0];
                if (PEN && a == 2'd1) m_len = int'(wd & ((32'd1 << CW) - 1));
                if (PEN && a == 2'd2 && !busy_p && m_len != 0) begin
                    m_mask = wd[DW-1:0];
                    m_end = k + m_len;
                end
                if (PEN && a == 2'd3 && wd[1]) m_sticky = 1'b0;
            end
            m_pd = PEN && k == m_end;
            if (m_pd) m_sticky = 1'b1;
        end
    endtask

    task automatic step(input logic rn, input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        reset_n = rn; bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
        @(posedge clk);
        model_edge(rn, a, cs, wn, wd);
        #1;
        last_out = 32'(bus.out_port);
        last_pd  = bus.pulse_done;
        last_rd  = bus.readdata;
        chk("out_port", last_out, 32'(m_data | ((k < m_end) ? m_mask : '0)));
        chk("pulse_done", 32'(last_pd), 32'(m_pd));
        chk("readdata", last_rd, m_rd);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        step(1'b1, a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        step(1'b1, a, 1'b1, 1'b1, 32'd0);
    endtask

    typedef struct {
        logic        rn;
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] eo;
        logic        ep;
        logic [31:0] er;
    } vec_t;

    function automatic vec_t mk(input logic rn, input logic [1:0] a, input logic cs, input logic wn,
                                input logic [31:0] wd, input logic [31:0] eo, input logic ep, input logic [31:0] er);
        vec_t v;
        v.rn = rn; v.a = a; v.cs = cs; v.wn = wn; v.wd = wd; v.eo = eo; v.ep = ep; v.er = er;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        vec_t tbl[22];
        int   hi, pds;
        logic [31:0] seen;
        tbl[0]  = mk(0, 0, 0, 1, 0,            1,       0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0,            1,       0, 0);
        tbl[2]  = mk(1, 3, 1, 1, 0,            1,       0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 0,            1,       0, p(1));
        tbl[4]  = mk(1, 0, 1, 0, 1,            1,       0, 1);
        tbl[5]  = mk(1, 0, 1, 1, 0,            1,       0, 1);
        tbl[6]  = mk(1, 0, 1, 0, 32'hFFFFFFFE, 32'hE,   0, 1);
        tbl[7]  = mk(1, 0, 1, 1, 0,            32'hE,   0, 32'hE);
        tbl[8]  = mk(1, 0, 1, 0, 0,            0,       0, 32'hE);
        tbl[9]  = mk(1, 1, 1, 0, 5,            0,       0, p(1));
        tbl[10] = mk(1, 2, 1, 0, 1,            p(1),    0, 0);
        tbl[11] = mk(1, 3, 1, 1, 0,            p(1),    0, p(32'h00050001));
        tbl[12] = mk(1, 3, 1, 1, 0,            p(1),    0, p(32'h00040001));
        tbl[13] = mk(1, 3, 1, 1, 0,            p(1),    0, p(32'h00030001));
        tbl[14] = mk(1, 3, 1, 1, 0,            p(1),    0, p(32'h00020001));
        tbl[15] = mk(1, 3, 1, 1, 0,            0,       PEN, p(32'h00010001));
        tbl[16] = mk(1, 3, 1, 1, 0,            0,       0, p(32'h2));
        tbl[17] = mk(1, 3, 1, 0, 2,            0,       0, p(32'h2));
        tbl[18] = mk(1, 3, 1, 1, 0,            0,       0, 0);
        tbl[19] = mk(1, 1, 1, 0, 0,            0,       0, p(5));
        tbl[20] = mk(1, 2, 1, 0, 1,            0,       0, 0);
        tbl[21] = mk(1, 3, 1, 1, 0,            0,       0, 0);
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rn, tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            chk($sformatf("tbl%0d_out", i), last_out, tbl[i].eo);
            chk($sformatf("tbl%0d_pd", i), 32'(last_pd), 32'(tbl[i].ep));
            chk($sformatf("tbl%0d_rd", i), last_rd, tbl[i].er);
        end

        // second GO one cycle into a 3-cycle pulse must neither retrigger nor change the mask
        wr_reg(2'd1, 32'd3);
        hi = 0; pds = 0; seen = '0;
        wr_reg(2'd2, 32'h3);
        hi += (last_out != 0); pds += last_pd; seen |= last_out;
        wr_reg(2'd2, 32'hC);
        hi += (last_out != 0); pds += last_pd; seen |= last_out;
        for (int i = 0; i < 6; i++) begin
            rd_reg(2'd3);
            hi += (last_out != 0); pds += last_pd; seen |= last_out;
        end
        chk("retrig_high_cycles", 32'(hi), p(3));
        chk("retrig_done_count", 32'(pds), p(1));
        chk("retrig_mask", seen, p(3));

        // reset in the middle of a 10-cycle pulse
        wr_reg(2'd1, 32'd10);
        wr_reg(2'd2, 32'h1);
        for (int i = 0; i < 3; i++) rd_reg(2'd3);
        step(1'b0, 2'd3, 1'b0, 1'b1, 32'd0);
        chk("midrst_out", last_out, RV);
        chk("midrst_rd", last_rd, 32'd0);
        pds = 0;
        for (int i = 0; i < 12; i++) begin
            rd_reg(2'd3);
            pds += last_pd;
        end
        chk("midrst_no_done", 32'(pds), 32'd0);
        chk("midrst_status", last_rd, 32'd0);
        rd_reg(2'd1);
        chk("midrst_len", last_rd, p(1));

        // W1C on the completion edge: set wins
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'd2);
        wr_reg(2'd2, 32'h2);
        rd_reg(2'd3);
        wr_reg(2'd3, 32'h2);
        chk("race_done_pulse", 32'(last_pd), 32'(PEN));
        rd_reg(2'd3);
        chk("race_sticky", last_rd, p(32'h2));
        wr_reg(2'd3, 32'h2);
        rd_reg(2'd3);
        chk("race_cleared", last_rd, 32'd0);

        // random traffic, short lengths favoured so pulses complete often
        for (int i = 0; i < 600; i++) begin
            logic [1:0]  a;
            logic [31:0] wd;
            a  = 2'($urandom_range(0, 3));
            wd = $urandom_range(0, 3) == 0 ? $urandom() : 32'($urandom_range(0, 7));
            step($urandom_range(0, 59) != 0, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/start_signal_write_start.md
# start_signal_write_start

Avalon-MM write-side parallel output port that drives the camera pipeline's start/control lines from the Nios II. It is the counterpart of the read-only start-signal input port. Software either writes a level directly, or arms a hardware-timed pulse of a programmed length so start strobes do not depend on software timing. A one-cycle `pulse_done` indication and a sticky status bit report pulse completion.

## Interface
Parameters:
- `DATA_WIDTH`, 1: width of `out_port`, 1..32.
- `RESET_VALUE`, 0: value of the DATA register after reset.
- `CNT_WIDTH`, 16: width of the pulse-length register and counter, 1..16.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `address` input 2: register select.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write is accepted on an edge where `chipselect & ~write_n`.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data.
- `out_port` output DATA_WIDTH: the driven lines.
- `pulse_done` output 1: one-cycle high when a pulse ends.

## Operation
Register map (unused bits read 0; writes to them are ignored):
- 0 DATA, R/W: `data_reg <= writedata[DATA_WIDTH-1:0]`.
- 1 PULSE_LEN, R/W: `len_reg <= writedata[CNT_WIDTH-1:0]`. Reset value 1.
- 2 PULSE_GO, W, reads 0: arms a pulse with `mask_reg <= writedata[DATA_WIDTH-1:0]`.
- 3 STATUS, R/W1C:
  - bit0 `busy`.
  - bit1 `done_sticky`; writing 1 to bit1 clears it.
  - bits[31:16] remaining count (zero-extended).

Output: `out_port = data_reg | (busy ? mask_reg : 0)`, driven from registers only (no combinational path from bus inputs).

State machine, IDLE / PULSE:
- IDLE -> PULSE on a PULSE_GO write when `len_reg != 0`.
  - Actions: `cnt <= len_reg`, `busy <= 1`.
  - A PULSE_GO write with `len_reg == 0` is ignored.
- PULSE:
  - `cnt` decrements on each edge.
  - On the edge where `cnt == 1`: `cnt <= 0`, `busy <= 0`, `pulse_done <= 1` for one cycle, `done_sticky <= 1`; state -> IDLE.
  - PULSE_GO writes while in PULSE are ignored; no retrigger and no mask change.

Boundary rules:
- A DATA write during PULSE takes effect immediately. Mask bits still force 1.
- A PULSE_LEN write during PULSE affects only the next pulse.
- Completion edge coinciding with a STATUS W1C write: set wins, so `done_sticky = 1`.
- Counter arithmetic is unsigned `CNT_WIDTH`; it never wraps below 0.
- Reset (mid-pulse or otherwise), on the next edge with `reset_n = 0`:
  - `data_reg = RESET_VALUE`, `len_reg = 1`, `mask_reg = 0`, `cnt = 0`, `busy = 0`, `done_sticky = 0`.
  - Outputs: `pulse_done = 0`, `readdata = 0`, `out_port = RESET_VALUE`.

## Timing
- Read latency is 1:
  - `readdata` updates on every edge from the mux at `address`, independent of `chipselect`.
  - Data is valid the cycle after the address is presented.
- No wait states; every write completes in one cycle.
- DATA write accepted at edge T: `out_port` shows the new value after edge T.
- PULSE_GO accepted at edge T with `len_reg = N`:
  - Mask bits of `out_port` are high for exactly N cycles, from after edge T through edge T+N.
  - `pulse_done` is high between edges T+N and T+N+1.
- STATUS read in the cycle after edge T returns busy = 1 and count = N.

## Configuration
- `START_SIGNAL_PULSE_EN` defined: PULSE_LEN, PULSE_GO, the counter, state machine, `pulse_done` and STATUS are implemented as above.
- `START_SIGNAL_PULSE_EN` not defined:
  - Only DATA exists; `out_port = data_reg`.
  - Addresses 1–3 read 0 and ignore writes.
  - `pulse_done` is tied 0.

## Test plan
- Reset with `RESET_VALUE = 1`: hold `reset_n` low for 2 edges -> `out_port = 1`, `readdata = 0`, STATUS reads 0, PULSE_LEN reads 1.
- Write DATA = 0x1, read address 0 -> `readdata = 0x00000001` one cycle later. Write 0xFFFFFFFE -> `out_port = 0`.
- PULSE_LEN = 5, PULSE_GO mask = 1, DATA = 0 -> `out_port` high exactly 5 cycles, `pulse_done` high 1 cycle, STATUS reads 0x2. Write STATUS 0x2 -> reads 0.
- PULSE_LEN = 0, then PULSE_GO -> `out_port` stays 0, busy stays 0. PULSE_LEN = 3 with a second GO 1 cycle after the first -> single 3-cycle pulse only.
- Pulse of length 10; assert `reset_n = 0` at cycle 4 -> `out_port = RESET_VALUE` after that edge, busy = 0, no `pulse_done`.
- STATUS W1C write on the completion edge -> `done_sticky` reads 1. Rebuild without `START_SIGNAL_PULSE_EN` -> PULSE_GO has no effect, address 3 reads 0.
